// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the UART baud-rate generator.
// Divisor tables are built by the top from these rates and its own parameters.
package uart_pkg;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_19200  = 2'd1,
        BAUD_57600  = 2'd2,
        BAUD_115200 = 2'd3
    } baud_sel_t;

    localparam int unsigned BAUD_RATES [4] = '{32'd9600, 32'd19200, 32'd57600, 32'd115200};

    // Nearest-integer division, used only on constants at elaboration.
    function automatic int unsigned div_round(input int unsigned clk, input int unsigned rate);
        return (clk + rate / 2) / rate;
    endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Generic mod-n counter with synchronous clear and a registered wrap strobe.
// The strobe is high in exactly the cycle the count shows n-1.
module uart_tick_counter #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] n,
    output logic [DIV_W-1:0] count,
    output logic             wrap
);

    logic [DIV_W-1:0] count_d;
    logic             wrap_d;

    always_comb begin
        count_d = '0;
        if (en && !clr && (count < n - DIV_W'(1))) begin
            count_d = count + DIV_W'(1);
        end
    end

    assign wrap_d = en && !clr && (count_d == n - DIV_W'(1));

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: TX bit clock/strobe and RX oversample/mid-bit strobes
// with a rate select that is only latched while both directions are idle.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [1:0] baud_sel,
    input  logic       tx_active,
    input  logic       rx_active,
    input  logic       rx_restart,
    output logic       tx_clk,
    output logic       tx_tick,
    output logic       rx_os_tick,
    output logic       rx_sample_tick
);

    localparam int unsigned IDX_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] TX_DIV_TABLE [4] = '{
        DIV_W'(div_round(CLK_FREQ, BAUD_RATES[0])),
        DIV_W'(div_round(CLK_FREQ, BAUD_RATES[1])),
        DIV_W'(div_round(CLK_FREQ, BAUD_RATES[2])),
        DIV_W'(div_round(CLK_FREQ, BAUD_RATES[3]))
    };

    localparam logic [DIV_W-1:0] OS_DIV_TABLE [4] = '{
        DIV_W'(div_round(CLK_FREQ, BAUD_RATES[0] * OVERSAMPLE)),
        DIV_W'(div_round(CLK_FREQ, BAUD_RATES[1] * OVERSAMPLE)),
        DIV_W'(div_round(CLK_FREQ, BAUD_RATES[2] * OVERSAMPLE)),
        DIV_W'(div_round(CLK_FREQ, BAUD_RATES[3] * OVERSAMPLE))
    };

    baud_sel_t        baud_q;
    logic [DIV_W-1:0] tx_div;
    logic [DIV_W-1:0] tx_half;
    logic [DIV_W-1:0] os_div;
    logic [DIV_W-1:0] tx_cnt;
    logic [DIV_W-1:0] os_cnt;
    logic             tx_wrap;
    logic             os_wrap;
    logic             tx_run_q;
    logic             rx_run_q;
    logic             tx_clr;
    logic             rx_clr;
    logic             tx_clk_q;
    logic             sample_q;
    logic [IDX_W-1:0] os_idx;

    assign tx_div  = TX_DIV_TABLE[baud_q];
    assign tx_half = tx_div >> 1;
    assign os_div  = OS_DIV_TABLE[baud_q];

    // The first active edge restarts the phase, so count 0 is visible right after it.
    assign tx_clr = !tx_run_q;
    assign rx_clr = rx_restart || !rx_run_q;

    uart_tick_counter #(.DIV_W(DIV_W)) u_tx_cnt (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (tx_active),
        .clr    (tx_clr),
        .n      (tx_div),
        .count  (tx_cnt),
        .wrap   (tx_wrap)
    );

    uart_tick_counter #(.DIV_W(DIV_W)) u_os_cnt (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (rx_active),
        .clr    (rx_clr),
        .n      (os_div),
        .count  (os_cnt),
        .wrap   (os_wrap)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            baud_q   <= BAUD_9600;
            tx_run_q <= 1'b0;
            rx_run_q <= 1'b0;
            tx_clk_q <= 1'b0;
            os_idx   <= '0;
            sample_q <= 1'b0;
        end else begin
            if (!tx_active && !rx_active) begin
                baud_q <= baud_sel_t'(baud_sel);
            end
            tx_run_q <= tx_active;
            rx_run_q <= rx_active;

            // High for counts 0 .. half-1: rises when the count returns to 0, falls at half.
            if (!tx_active) begin
                tx_clk_q <= 1'b0;
            end else if (tx_clr || tx_wrap) begin
                tx_clk_q <= 1'b1;
            end else if (tx_cnt == tx_half - DIV_W'(1)) begin
                tx_clk_q <= 1'b0;
            end

            // os_idx counts oversample ticks already issued in the current bit.
            if (!rx_active || rx_clr) begin
                os_idx <= '0;
            end else if (os_wrap) begin
                os_idx <= (os_idx == IDX_W'(OVERSAMPLE - 1)) ? '0 : os_idx + 1'b1;
            end

            sample_q <= rx_active && !rx_clr
                        && (os_cnt == os_div - DIV_W'(2))
                        && (os_idx == IDX_W'(OVERSAMPLE / 2 - 1));
        end
    end

    assign tx_clk         = tx_clk_q;
    assign tx_tick        = tx_wrap;
    assign rx_os_tick     = os_wrap;
    assign rx_sample_tick = sample_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: per-cycle arithmetic phase model plus
// directed spacing checks against hand-computed divisor values.
module tb_uart_baud_gen;

    localparam int OS = 16;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic [1:0] baud_sel;
    logic       tx_active;
    logic       rx_active;
    logic       rx_restart;
    logic       tx_clk;
    logic       tx_tick;
    logic       rx_os_tick;
    logic       rx_sample_tick;

    always #5 clk_in = ~clk_in;

    uart_baud_gen #(
        .CLK_FREQ   (50_000_000),
        .OVERSAMPLE (OS),
        .DIV_W      (16)
    ) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .baud_sel       (baud_sel),
        .tx_active      (tx_active),
        .rx_active      (rx_active),
        .rx_restart     (rx_restart),
        .tx_clk         (tx_clk),
        .tx_tick        (tx_tick),
        .rx_os_tick     (rx_os_tick),
        .rx_sample_tick (rx_sample_tick)
    );

    int txd_tab [4] = '{5208, 2604, 868, 434};
    int osd_tab [4] = '{326, 163, 54, 27};

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: each output is a pure function of the cycles elapsed since
    // the phase origin (activation edge or restart edge) and the latched divisor.
    int m_baud = 0;
    bit tx_on = 0, rx_on = 0;
    int tx_org, rx_org, tx_d, rx_d;
    bit e_clk = 0, e_tick = 0, e_os = 0, e_smp = 0;

    always @(posedge clk_in) begin
        int k;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_baud = 0; tx_on = 0; rx_on = 0;
            e_clk = 0; e_tick = 0; e_os = 0; e_smp = 0;
        end else begin
            if (tx_active) begin
                if (!tx_on) begin
                    tx_org = cyc;
                    tx_d   = txd_tab[m_baud];
                end
                tx_on  = 1;
                k      = (cyc - tx_org) % tx_d;
                e_clk  = (k < tx_d / 2);
                e_tick = (k == tx_d - 1);
            end else begin
                tx_on = 0; e_clk = 0; e_tick = 0;
            end
            if (rx_active) begin
                if (!rx_on || rx_restart) begin
                    rx_org = cyc;
                    rx_d   = osd_tab[m_baud];
                end
                rx_on = 1;
                k     = cyc - rx_org;
                e_os  = ((k % rx_d) == rx_d - 1);
                e_smp = ((k % (OS * rx_d)) == (OS / 2) * rx_d - 1);
            end else begin
                rx_on = 0; e_os = 0; e_smp = 0;
            end
            if (!tx_active && !rx_active) m_baud = int'(baud_sel);
        end
        #1;
        tests++;
        if ({tx_clk, tx_tick, rx_os_tick, rx_sample_tick} !== {e_clk, e_tick, e_os, e_smp}) begin
            fails++;
            if (fails <= 20)
                $display("FAIL model cycle %0d clk/tick/os/smp got %b%b%b%b want %b%b%b%b",
                         cyc, tx_clk, tx_tick, rx_os_tick, rx_sample_tick,
                         e_clk, e_tick, e_os, e_smp);
        end
    end

    function automatic bit pick(input int which);
        case (which)
            0:       return tx_tick;
            1:       return rx_os_tick;
            default: return rx_sample_tick;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Returns the cycle number of the next strobe (-1 if the bound expires) and
    // how many sampled cycles tx_clk was high on the way.
    task automatic wait_sig(input int which, input int limit, output int at, output int hi);
        at = -1;
        hi = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_in);
            if (tx_clk) hi++;
            if (pick(which)) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r, e, at, at2, hi, s, s2;
        rst_n = 1'b0; tx_active = 1'b1; rx_active = 1'b1; rx_restart = 1'b0; baud_sel = 2'd0;

        // Reset with both directions requested
        repeat (3) @(negedge clk_in);
        check("reset_outputs", int'({tx_clk, tx_tick, rx_os_tick, rx_sample_tick}), 0);
        rst_n = 1'b1;
        r = cyc + 1;
        #1;
        check("release_outputs", int'({tx_clk, tx_tick, rx_os_tick, rx_sample_tick}), 0);

        // 9600 TX for ten bits; rate select moved to 115200 mid-frame must not apply
        wait_sig(0, 6000, at, hi);
        check("tx9600_first_tick", at - r + 1, 5208);
        check("tx9600_high_bit0", hi, 2604);
        for (int b = 1; b < 10; b++) begin
            if (b == 5) baud_sel = 2'd3;
            wait_sig(0, 6000, at2, hi);
            check("tx9600_spacing", at2 - at, 5208);
            check("tx9600_high", hi, 2604);
            at = at2;
        end
        check("tx9600_ten_ticks", at - r + 1, 52080);

        // Idle latches 115200; then drop TX at count 200 of a bit
        tx_active = 1'b0; rx_active = 1'b0;
        repeat (5) @(negedge clk_in);
        tx_active = 1'b1;
        e = cyc + 1;
        wait_sig(0, 1000, at, hi);
        check("tx115k_first_tick", at - e + 1, 434);
        for (int b = 0; b < 2; b++) begin
            wait_sig(0, 1000, at2, hi);
            check("tx115k_spacing", at2 - at, 434);
            at = at2;
        end
        repeat (201) @(negedge clk_in);
        check("tx115k_clk_before_drop", int'(tx_clk), 1);
        tx_active = 1'b0;
        @(negedge clk_in);
        check("tx_drop_clk_low", int'(tx_clk), 0);
        wait_sig(0, 1000, at, hi);
        check("tx_drop_no_tick", at, -1);

        // RX at 19200 with restart
        baud_sel = 2'd1;
        repeat (3) @(negedge clk_in);
        rx_active = 1'b1; rx_restart = 1'b1;
        e = cyc + 1;
        @(negedge clk_in);
        rx_restart = 1'b0;
        wait_sig(1, 400, at, hi);
        check("rx19200_first_os", at - e + 1, 163);
        wait_sig(2, 2000, s, hi);
        check("rx19200_first_sample", s - e + 1, 1304);
        for (int b = 0; b < 2; b++) begin
            wait_sig(2, 3000, s2, hi);
            check("rx19200_sample_spacing", s2 - s, 2608);
            s = s2;
        end
        // Restart landing on an oversample wrap suppresses that tick
        repeat (162) @(negedge clk_in);
        rx_restart = 1'b1;
        e = cyc + 1;
        @(negedge clk_in);
        rx_restart = 1'b0;
        check("rx_restart_suppress_os", int'(rx_os_tick), 0);
        wait_sig(1, 400, at, hi);
        check("rx_restart_first_os", at - e + 1, 163);
        wait_sig(2, 2000, s, hi);
        check("rx_restart_first_sample", s - e + 1, 1304);

        // Concurrent TX and RX at 57600
        rx_active = 1'b0;
        baud_sel = 2'd2;
        repeat (3) @(negedge clk_in);
        tx_active = 1'b1;
        repeat (300) @(negedge clk_in);
        rx_active = 1'b1; rx_restart = 1'b1;
        @(negedge clk_in);
        rx_restart = 1'b0;
        wait_sig(0, 1000, at, hi);
        for (int b = 0; b < 3; b++) begin
            wait_sig(0, 1000, at2, hi);
            check("conc_tx_spacing", at2 - at, 868);
            at = at2;
        end
        wait_sig(2, 1000, s, hi);
        for (int b = 0; b < 2; b++) begin
            wait_sig(2, 1000, s2, hi);
            check("conc_rx_sample_spacing", s2 - s, 864);
            s = s2;
        end
        tx_active = 1'b0; rx_active = 1'b0;

        // Randomised traffic: rate changes, restarts, activity toggles, mid-frame resets
        for (int seg = 0; seg < 8; seg++) begin
            int n;
            baud_sel  = 2'($urandom_range(0, 3));
            tx_active = 1'($urandom_range(0, 1));
            rx_active = 1'($urandom_range(0, 1));
            n = $urandom_range(200, 1100);
            for (int i = 0; i < n; i++) begin
                @(negedge clk_in);
                rx_restart = ($urandom_range(0, 99) < 2);
                if ($urandom_range(0, 499) == 0) tx_active = ~tx_active;
                if ($urandom_range(0, 499) == 0) rx_active = ~rx_active;
                if ($urandom_range(0, 199) == 0) baud_sel = 2'($urandom_range(0, 3));
                rst_n = ($urandom_range(0, 999) != 0);
            end
            rst_n = 1'b1;
            rx_restart = 1'b0;
        end

        @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
